xgmii_rx_frame_checker: RTL



---
 rtl/xgmii_pkg.sv | 27 ++
 rtl/xgmii_term_decode.sv | 34 +++
 rtl/xgmii_rx_frame_checker.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/xgmii_pkg.sv
// Shared XGMII character codes, checker FSM states and bad-frame reason codes.
`timescale 1ns/1ps
package xgmii_pkg;
  localparam logic [7:0] XGMII_START   = 8'hFB;
  localparam logic [7:0] XGMII_TERM    = 8'hFD;
  localparam logic [7:0] XGMII_IDLE    = 8'h07;
  localparam logic [7:0] XGMII_ERR     = 8'hFE;
  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRE_HI,
    ST_DATA,
    ST_DROP
  } rx_state_e;

  typedef enum logic [2:0] {
    ERR_NONE           = 3'd0,
    ERR_PREAMBLE       = 3'd1,
    ERR_CTRL_CHAR      = 3'd2,
    ERR_RUNT           = 3'd3,
    ERR_OVERSIZE       = 3'd4,
    ERR_START_IN_FRAME = 3'd5,
    ERR_BAD_TERM       = 3'd6
  } err_code_e;
endpackage

// File: rtl/xgmii_term_decode.sv
// Combinational classification of an XGMII word: terminate position/legality and error chars.
`timescale 1ns/1ps
module xgmii_term_decode
  import xgmii_pkg::*;
(
  input  logic [63:0] rxd,
  input  logic [7:0]  rxc,
  output logic        term_valid,
  output logic [2:0]  term_lane,
  output logic        term_malformed,
  output logic        has_err_char
);
  logic first_is_term;
  logic mask_ok;
  logic tail_idle;

  always_comb begin
    term_lane    = 3'd0;
    has_err_char = 1'b0;
    tail_idle    = 1'b1;
    // Descending scan so the lowest control lane wins.
    for (int n = 7; n >= 0; n--) begin
      if (rxc[n]) term_lane = 3'(n);
    end
    for (int n = 0; n < 8; n++) begin
      if (rxc[n] && (rxd[8*n +: 8] == XGMII_ERR)) has_err_char = 1'b1;
      if ((3'(n) > term_lane) && (rxd[8*n +: 8] != XGMII_IDLE)) tail_idle = 1'b0;
    end
    first_is_term  = (rxc != 8'h00) && (rxd[{term_lane, 3'b000} +: 8] == XGMII_TERM);
    mask_ok        = (rxc == (8'hFF << term_lane));
    term_valid     = first_is_term && mask_ok && tail_idle;
    term_malformed = first_is_term && !term_valid;
  end
endmodule

// File: rtl/xgmii_rx_frame_checker.sv
// XGMII RX frame checker: delineates frames, validates preamble/length/control chars,
// reports good/bad pulses and saturating frame statistics.
`timescale 1ns/1ps
module xgmii_rx_frame_checker
  import xgmii_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int CNT_W   = 32
) (
  input  logic             rx_user_clk_i,
  input  logic             rx_user_rst_i,
  input  logic [63:0]      xgmii_rxd_i,
  input  logic [7:0]       xgmii_rxc_i,
  input  logic             xgmii_rxd_vld_i,
  output logic             frame_good_o,
  output logic             frame_bad_o,
  output logic [15:0]      frame_len_o,
  output logic [2:0]       err_code_o,
  output logic             in_frame_o,
  output logic [CNT_W-1:0] good_cnt_o,
  output logic [CNT_W-1:0] bad_cnt_o
);
  localparam logic [15:0] MIN_L = 16'(MIN_LEN);
  localparam logic [15:0] MAX_L = 16'(MAX_LEN);

  function automatic logic [15:0] len_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] a);
    return (&a) ? a : a + CNT_W'(1);
  endfunction

  logic       term_valid;
  logic [2:0] term_lane;
  logic       term_malformed;
  logic       has_err_char;

  xgmii_term_decode u_term_decode (
    .rxd            (xgmii_rxd_i),
    .rxc            (xgmii_rxc_i),
    .term_valid     (term_valid),
    .term_lane      (term_lane),
    .term_malformed (term_malformed),
    .has_err_char   (has_err_char)
  );

  logic any_start, any_term, all_idle;
  logic start_l0, start_l0_ok, start_l4_ok, pre_hi_ok;

  always_comb begin
    any_start = 1'b0;
    any_term  = 1'b0;
    all_idle  = (xgmii_rxc_i == 8'hFF);
    for (int n = 0; n < 8; n++) begin
      if (xgmii_rxc_i[n] && (xgmii_rxd_i[8*n +: 8] == XGMII_START)) any_start = 1'b1;
      if (xgmii_rxc_i[n] && (xgmii_rxd_i[8*n +: 8] == XGMII_TERM))  any_term  = 1'b1;
      if (xgmii_rxd_i[8*n +: 8] != XGMII_IDLE) all_idle = 1'b0;
    end
  end

  assign start_l0    = (xgmii_rxc_i == 8'h01) && (xgmii_rxd_i[7:0] == XGMII_START);
  assign start_l0_ok = start_l0 && (xgmii_rxd_i[55:8] == {6{PREAMBLE_BYTE}})
                       && (xgmii_rxd_i[63:56] == SFD_BYTE);
  assign start_l4_ok = (xgmii_rxc_i == 8'hF0) && (xgmii_rxd_i[39:32] == XGMII_START)
                       && (xgmii_rxd_i[63:40] == {3{PREAMBLE_BYTE}});
  assign pre_hi_ok   = (xgmii_rxc_i == 8'h00) && (xgmii_rxd_i[23:0] == {3{PREAMBLE_BYTE}})
                       && (xgmii_rxd_i[31:24] == SFD_BYTE);

  rx_state_e   state_p1, state_nxt;
  logic [15:0] len_p1, len_nxt, len_data, len_term;
  logic        good_nxt, bad_nxt, len_upd;
  err_code_e   code_nxt;

  assign len_data = len_add(len_p1, 16'd8);
  assign len_term = len_add(len_p1, {13'd0, term_lane});

  always_comb begin
    state_nxt = state_p1;
    len_nxt   = len_p1;
    good_nxt  = 1'b0;
    bad_nxt   = 1'b0;
    code_nxt  = ERR_NONE;
    len_upd   = 1'b0;
    case (state_p1)
      ST_IDLE: begin
        if (start_l0) begin
          if (start_l0_ok) begin
            state_nxt = ST_DATA;
            len_nxt   = 16'd0;
          end else begin
            bad_nxt   = 1'b1;
            code_nxt  = ERR_PREAMBLE;
            state_nxt = ST_DROP;
          end
        end else if (start_l4_ok) begin
          state_nxt = ST_PRE_HI;
        end
      end
      ST_PRE_HI: begin
        if (pre_hi_ok) begin
          state_nxt = ST_DATA;
          len_nxt   = 16'd4;
        end else begin
          bad_nxt   = 1'b1;
          code_nxt  = ERR_PREAMBLE;
          state_nxt = ST_DROP;
        end
      end
      ST_DATA: begin
        if (xgmii_rxc_i == 8'h00) begin
          len_nxt = len_data;
          if (len_data > MAX_L) begin
            bad_nxt   = 1'b1;
            code_nxt  = ERR_OVERSIZE;
            state_nxt = ST_DROP;
          end
        end else if (any_start) begin
          // A clean lane-0 start aborts the current frame and begins a new one.
          bad_nxt   = 1'b1;
          code_nxt  = ERR_START_IN_FRAME;
          len_nxt   = 16'd0;
          state_nxt = start_l0_ok ? ST_DATA : ST_DROP;
        end else if (term_valid) begin
          state_nxt = ST_IDLE;
          len_upd   = 1'b1;
          if (len_term < MIN_L) begin
            bad_nxt  = 1'b1;
            code_nxt = ERR_RUNT;
          end else if (len_term > MAX_L) begin
            bad_nxt  = 1'b1;
            code_nxt = ERR_OVERSIZE;
          end else begin
            good_nxt = 1'b1;
          end
        end else begin
          bad_nxt   = 1'b1;
          state_nxt = ST_DROP;
          code_nxt  = (!has_err_char && term_malformed) ? ERR_BAD_TERM : ERR_CTRL_CHAR;
        end
      end
      ST_DROP: begin
        if (any_term || all_idle) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Registered stage: state, length and all outputs update from qualified words only.
  always_ff @(posedge rx_user_clk_i or posedge rx_user_rst_i) begin
    if (rx_user_rst_i) begin
      state_p1     <= ST_IDLE;
      len_p1       <= '0;
      frame_good_o <= 1'b0;
      frame_bad_o  <= 1'b0;
      frame_len_o  <= '0;
      err_code_o   <= '0;
      in_frame_o   <= 1'b0;
      good_cnt_o   <= '0;
      bad_cnt_o    <= '0;
    end else begin
      frame_good_o <= 1'b0;
      frame_bad_o  <= 1'b0;
      if (xgmii_rxd_vld_i) begin
        state_p1     <= state_nxt;
        len_p1       <= len_nxt;
        frame_good_o <= good_nxt;
        frame_bad_o  <= bad_nxt;
        in_frame_o   <= (state_nxt == ST_PRE_HI) || (state_nxt == ST_DATA);
        if (bad_nxt) begin
          err_code_o <= code_nxt;
          bad_cnt_o  <= cnt_inc(bad_cnt_o);
        end
        if (good_nxt) good_cnt_o <= cnt_inc(good_cnt_o);
        if (len_upd) frame_len_o <= len_term;
      end
    end
  end
endmodule
